// File: rtl/tgate_switch_sequencer.sv
// tgate_switch_sequencer: break-before-make sel/selb sequencer for N_GATES gates on one net (req valid/ready in; sel/selb, busy, done, active_valid/active_idx out)
module tgate_switch_sequencer #(
  parameter int SEL_W = 2,
  parameter int DEAD_CYCLES = 2,
  parameter int SETTLE_CYCLES = 3,
  localparam int N_GATES = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SEL_W-1:0]   req_sel,
  input  logic               req_off,
  output logic [N_GATES-1:0] sel,
  output logic [N_GATES-1:0] selb,
  output logic               busy,
  output logic               done,
  output logic               active_valid,
  output logic [SEL_W-1:0]   active_idx
);
  typedef enum logic [1:0] {IDLE, DEAD, SETTLE, ACK} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [N_GATES-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] tgt_sel_q, tgt_sel_d, act_idx_q, act_idx_d;
  logic tgt_off_q, tgt_off_d, act_v_q, act_v_d;
  logic done_q, ready_q, busy_q;
  logic accept;
  assign accept = req_valid & ready_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    tgt_sel_d = tgt_sel_q;
    tgt_off_d = tgt_off_q;
    act_idx_d = act_idx_q;
    act_v_d = act_v_q;
    case (state_q)
      IDLE: if (accept) begin
        if (!req_off && act_v_q && req_sel == act_idx_q) state_d = ACK;
        else begin
          state_d = DEAD;
          sel_d = '0;
          act_v_d = 1'b0;
          cnt_d = 8'(DEAD_CYCLES - 1);
          tgt_sel_d = req_sel;
          tgt_off_d = req_off;
        end
      end
      DEAD: if (cnt_q == 8'd0) begin
        if (tgt_off_q) state_d = ACK;
        else begin
          state_d = SETTLE;
          sel_d = N_GATES'(1) << tgt_sel_q;
          act_idx_d = tgt_sel_q;
          act_v_d = 1'b1;
          cnt_d = 8'(SETTLE_CYCLES - 1);
        end
      end else cnt_d = cnt_q - 8'd1;
      SETTLE: if (cnt_q == 8'd0) state_d = ACK; else cnt_d = cnt_q - 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sel_q <= '0;
      tgt_sel_q <= '0;
      tgt_off_q <= 1'b0;
      act_idx_q <= '0;
      act_v_q <= 1'b0;
      done_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      tgt_sel_q <= tgt_sel_d;
      tgt_off_q <= tgt_off_d;
      act_idx_q <= act_idx_d;
      act_v_q <= act_v_d;
      done_q <= state_d == ACK;
      ready_q <= state_d == IDLE;
      busy_q <= state_d != IDLE;
    end
  end
  assign sel = sel_q;
  assign selb = ~sel_q;
  assign req_ready = ready_q;
  assign busy = busy_q;
  assign done = done_q;
  assign active_valid = act_v_q;
  assign active_idx = act_idx_q;
endmodule

// File: tb/tb_tgate_switch_sequencer.sv
// tb_tgate_switch_sequencer: table-driven check of break-before-make timing plus reset corner cases
module tb_tgate_switch_sequencer;
  localparam int D = 2;
  localparam int S = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] req_sel = '0;
  logic req_off = 1'b0;
  logic [3:0] sel, selb;
  logic busy, done, active_valid;
  logic [1:0] active_idx;
  int tests = 0;
  int fails = 0;
  tgate_switch_sequencer #(.SEL_W(2), .DEAD_CYCLES(D), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_off(req_off), .sel(sel), .selb(selb), .busy(busy),
    .done(done), .active_valid(active_valid), .active_idx(active_idx)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic off;
    logic [1:0] idx;
    logic brk;
    logic [3:0] fin;
    int done_at;
    logic av;
    logic [1:0] aidx;
  } vec_t;
  vec_t v[8];
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    tests++;
    if ($countones(sel) > 1 || selb !== ~sel) begin
      fails++;
      $display("FAIL invariant: sel=%b selb=%b at %0t", sel, selb, $time);
    end
  end
  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", int'(req_ready), 1);
  endtask
  task automatic issue(input logic off, input logic [1:0] idx);
    @(negedge clk);
    req_valid = 1'b1; req_off = off; req_sel = idx;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask
  task automatic run(input vec_t t, input int n);
    logic [3:0] es;
    wait_ready();
    issue(t.off, t.idx);
    for (int j = 0; j <= t.done_at + 1; j++) begin
      es = !t.brk ? t.fin : (j < D ? 4'b0000 : t.fin);
      chk($sformatf("v%0d_sel_j%0d", n, j), int'(sel), int'(es));
      chk($sformatf("v%0d_done_j%0d", n, j), int'(done), int'(j == t.done_at));
      if (j <= t.done_at) chk($sformatf("v%0d_busy_j%0d", n, j), int'(busy), 1);
      if (j < t.done_at + 1) begin
        @(posedge clk); #1;
      end
    end
    chk($sformatf("v%0d_ready", n), int'(req_ready), 1);
    chk($sformatf("v%0d_busy_end", n), int'(busy), 0);
    chk($sformatf("v%0d_av", n), int'(active_valid), int'(t.av));
    if (t.av) chk($sformatf("v%0d_aidx", n), int'(active_idx), int'(t.aidx));
  endtask
  initial begin
    v[0] = '{1'b0, 2'd2, 1'b1, 4'b0100, D + S, 1'b1, 2'd2};
    v[1] = '{1'b0, 2'd1, 1'b1, 4'b0010, D + S, 1'b1, 2'd1};
    v[2] = '{1'b0, 2'd1, 1'b0, 4'b0010, 0,     1'b1, 2'd1};
    v[3] = '{1'b1, 2'd1, 1'b1, 4'b0000, D,     1'b0, 2'd0};
    v[4] = '{1'b0, 2'd0, 1'b1, 4'b0001, D + S, 1'b1, 2'd0};
    v[5] = '{1'b0, 2'd3, 1'b1, 4'b1000, D + S, 1'b1, 2'd3};
    v[6] = '{1'b1, 2'd3, 1'b1, 4'b0000, D,     1'b0, 2'd0};
    v[7] = '{1'b1, 2'd2, 1'b1, 4'b0000, D,     1'b0, 2'd0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_selb", int'(selb), 15);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_av", int'(active_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_ready", int'(req_ready), 1);
    for (int i = 0; i < 8; i++) run(v[i], i);
    wait_ready();
    issue(1'b0, 2'd3);
    repeat (D + 1) @(posedge clk);
    #1;
    chk("mid_sel_on", int'(sel), 8);
    chk("mid_busy", int'(busy), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mr_sel", int'(sel), 0);
    chk("mr_selb", int'(selb), 15);
    chk("mr_done", int'(done), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_av", int'(active_valid), 0);
    chk("mr_ready", int'(req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mr_rel_ready", int'(req_ready), 1);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("mr_nodone_%0d", j), int'(done), 0);
      chk($sformatf("mr_off_%0d", j), int'(sel), 0);
      @(posedge clk); #1;
    end
    run('{1'b0, 2'd3, 1'b1, 4'b1000, D + S, 1'b1, 2'd3}, 8);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
